// File: rtl/spi_buffer.sv
// spi_buffer -- SPI-slave receive buffer (mode-0 style).
//
// Samples DI MSB-first on every rising CLK while CS is low. Each time DATA_WIDTH bits have
// been collected, the completed word is published on Buffer and Changed pulses high for
// exactly one CLK cycle. Deasserting CS discards any partial word, so the next selected
// transfer always starts at the MSB.
//
// Ports:
//   CLK     in   SPI serial clock; all state changes on its rising edge.
//   RST     in   Asynchronous, active-high reset.
//   CS      in   Chip select, active low (0 = transfer active, 1 = idle).
//   DI      in   Serial data in (MOSI), MSB first.
//   Buffer  out  Last completely received word (registered).
//   Changed out  One-cycle strobe, high for the cycle after a word completes.
//
// DATA_WIDTH must be at least 2.
module spi_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CS,
  input  logic                  DI,
  output logic [DATA_WIDTH-1:0] Buffer,
  output logic                  Changed
);

  localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(DATA_WIDTH - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  // Only DATA_WIDTH-1 bits are stored; the final bit goes straight from DI into Buffer.
  logic [DATA_WIDTH-2:0] shiftQ, shiftD;
  logic [DATA_WIDTH-2:0] shiftIn;
  logic [CntWidth-1:0]   countQ, countD;
  logic [DATA_WIDTH-1:0] bufferQ, bufferD;
  logic                  changedQ, changedD;
  logic                  lastBit;

  // Shift-in value; a 2-bit word keeps a single stored bit, so there is nothing to shift.
  generate
    if (DATA_WIDTH > 2) begin : gShiftWide
      assign shiftIn = {shiftQ[DATA_WIDTH-3:0], DI};
    end else begin : gShiftNarrow
      assign shiftIn = DI;
    end
  endgenerate

  assign lastBit = (countQ == LastCnt);

  always_comb begin
    shiftD   = shiftQ;
    countD   = countQ;
    bufferD  = bufferQ;
    changedD = 1'b0;

    if (CS) begin
      // Deselected: drop the partial word. Stale shift bits are harmless because they are
      // fully overwritten before the next publish.
      countD = '0;
    end else if (lastBit) begin
      bufferD  = {shiftQ, DI};
      changedD = 1'b1;
      countD   = '0;
    end else begin
      shiftD = shiftIn;
      countD = countQ + CntOne;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shiftQ   <= '0;
      countQ   <= '0;
      bufferQ  <= '0;
      changedQ <= 1'b0;
    end else begin
      shiftQ   <= shiftD;
      countQ   <= countD;
      bufferQ  <= bufferD;
      changedQ <= changedD;
    end
  end

  assign Buffer  = bufferQ;
  assign Changed = changedQ;

endmodule

// File: tb/tb_spi_buffer.sv
module tb_spi_buffer;

  logic       CLK;
  logic       RST;
  logic       CS;
  logic       DI;
  logic [7:0] Buffer;
  logic       Changed;

  int numChecks;
  int numFails;
  int pulseCount;

  spi_buffer #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CS     (CS),
    .DI     (DI),
    .Buffer (Buffer),
    .Changed(Changed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit before a rising edge, sample #1 after it, then wiggle DI between edges.
  task automatic sendBit(input logic b);
    @(negedge CLK);
    CS = 1'b0;
    DI = b;
    @(posedge CLK);
    #1;
    if (Changed === 1'b1) pulseCount++;
    DI = ~b;
  endtask

  task automatic idleClock();
    @(negedge CLK);
    CS = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic sendByte(input string tag, input logic [7:0] v, input logic [7:0] oldBuf);
    for (int i = 7; i >= 0; i--) begin
      sendBit(v[i]);
      if (i > 0) begin
        checkValue({tag, " changed mid"}, {31'd0, Changed}, 32'd0);
        checkValue({tag, " buffer mid"}, {24'd0, Buffer}, {24'd0, oldBuf});
      end
    end
    checkValue({tag, " buffer"}, {24'd0, Buffer}, {24'd0, v});
    checkValue({tag, " changed"}, {31'd0, Changed}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    numChecks  = 0;
    numFails   = 0;
    pulseCount = 0;
    RST = 1'b1;
    CS  = 1'b0;
    DI  = 1'b1;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      CS = i[0];
      DI = ~i[1];
    end
    #1;
    checkValue("reset buffer", {24'd0, Buffer}, 32'h00);
    checkValue("reset changed", {31'd0, Changed}, 32'd0);

    @(negedge CLK);
    RST = 1'b0;
    CS  = 1'b1;
    idleClock();
    idleClock();
    checkValue("idle buffer", {24'd0, Buffer}, 32'h00);
    checkValue("idle changed", {31'd0, Changed}, 32'd0);

    // Single byte then back-to-back byte.
    sendByte("byte 7A", 8'h7A, 8'h00);
    sendByte("byte 80", 8'h80, 8'h7A);
    checkValue("pulse count b2b", pulseCount, 32'd2);

    // Deselect / reselect.
    for (int i = 0; i < 2; i++) begin
      idleClock();
      checkValue("desel buffer", {24'd0, Buffer}, 32'h80);
      checkValue("desel changed", {31'd0, Changed}, 32'd0);
    end
    sendByte("byte 0C", 8'h0C, 8'h80);
    sendByte("byte 40", 8'h40, 8'h0C);
    idleClock();
    checkValue("extra changed", {31'd0, Changed}, 32'd0);
    checkValue("extra buffer", {24'd0, Buffer}, 32'h40);

    // Aborted word: 5 bits of 11111, deselect, then a full A5.
    for (int i = 0; i < 5; i++) begin
      sendBit(1'b1);
      checkValue("abort changed", {31'd0, Changed}, 32'd0);
    end
    idleClock();
    checkValue("abort buffer", {24'd0, Buffer}, 32'h40);
    sendByte("byte A5", 8'hA5, 8'h40);
    checkValue("pulse count total", pulseCount, 32'd5);

    // Async reset mid-word.
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    #2;
    RST = 1'b1;
    #1;
    checkValue("async rst buffer", {24'd0, Buffer}, 32'h00);
    checkValue("async rst changed", {31'd0, Changed}, 32'd0);
    RST = 1'b0;
    sendByte("byte 3C", 8'h3C, 8'h00);
    idleClock();
    checkValue("final changed", {31'd0, Changed}, 32'd0);
    checkValue("final buffer", {24'd0, Buffer}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/spi_buffer.md
Name: spi_buffer

Overview:
- SPI-slave receive buffer, mode-0 style: samples serial data MSB-first on rising CLK while chip-select is low.
- After each complete byte, publishes the byte on a parallel output and pulses a one-cycle "new byte" strobe.
- Sits between an external SPI master's DI/CS/CLK pins and downstream command/data logic, which consumes Buffer when Changed is high.

Parameters:
- DATA_WIDTH, 8, bits per received word; Buffer width and bits counted per word.

Ports:
- CLK  input  1  SPI serial clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- CS  input  1  chip select, active low; 0 = transfer active, 1 = idle/deselected.
- DI  input  1  serial data in (MOSI), MSB first.
- Buffer  output  DATA_WIDTH  last completely received word, registered.
- Changed  output  1  one-CLK-cycle strobe; high for the cycle after a word completes.

Behaviour:
- Internal state:
  - shift register, DATA_WIDTH-1 bits;
  - bit counter, range 0..DATA_WIDTH-1, width clog2(DATA_WIDTH).
- Reset (RST=1, asynchronous, overrides all): shift register=0, counter=0, Buffer=0, Changed=0. Held while RST high; normal operation resumes on the first rising CLK after RST falls.
- Rising CLK with CS=1 (idle):
  - counter cleared to 0; partial word discarded (shift register may keep stale bits, never published);
  - Buffer holds its value;
  - Changed <= 0.
- Rising CLK with CS=0 and counter < DATA_WIDTH-1:
  - shift register <= {shift[DATA_WIDTH-3:0], DI};
  - counter <= counter+1;
  - Changed <= 0; Buffer holds.
- Rising CLK with CS=0 and counter == DATA_WIDTH-1 (last bit):
  - Buffer <= {shift register, DI}, so the first received bit lands in Buffer[DATA_WIDTH-1];
  - Changed <= 1;
  - counter wraps to 0.
- Latency: Buffer and Changed update on the same rising edge that samples the last bit, visible immediately after that edge.
- Changed lasts exactly one CLK cycle. It deasserts on the next rising edge regardless of CS, unless that edge completes another word, which is impossible for DATA_WIDTH ≥ 2.
- Back-to-back words with CS held low: counter wraps, and the next DATA_WIDTH bits form the next word with no gap cycle required.
- CS rising mid-word: partial bits are lost; the next CS-low transfer starts at bit 0 (MSB).
- CS unknown/X: no requirement; the bench must drive CS to a known level or hold RST until it does.
- No CLK edges: outputs hold indefinitely. There is no timeout.
- DI is sampled only on rising CLK; DI changes between edges have no effect.

Test Plan:
- Reset: RST=1 with arbitrary DI/CS/CLK activity -> Buffer=0x00, Changed=0. Release RST, CS=1, two clocks -> outputs unchanged.
- Single byte: CS=0, shift 0x7A MSB-first over 8 rising edges -> after the 8th edge Buffer=0x7A and Changed=1; after the 7th edge Buffer still holds the old value and Changed=0.
- Back-to-back: continue CS=0 and shift 0x80 immediately -> Changed=0 during bits 1-7, then Buffer=0x80 with Changed=1 after the 8th edge; exactly two Changed pulses total.
- Deselect/reselect: CS=1 for two clocks (Buffer stays 0x80, Changed=0), CS=0, shift 0x0C then 0x40 -> Buffer=0x0C then 0x40, each with a one-cycle Changed pulse. One extra clock afterwards -> Changed=0, Buffer=0x40.
- Aborted word: CS=0, shift 5 bits, CS=1 for one clock, CS=0, shift 0xA5 -> Buffer=0xA5 after 8 further edges; no Changed pulse during the aborted word.
- Async reset mid-word: after 4 bits, pulse RST between clock edges -> Buffer=0 and Changed=0 immediately; the next 8 bits of 0x3C with CS=0 give Buffer=0x3C.
